// File: rtl/latch_mapper_gen.sv
// Generic single-latch NES mapper (UxROM/GxROM/203 class): one CPU-written
// register drives PRG/CHR banking, optional mirroring and a write-once lock.
module latch_mapper_gen #(
  parameter int PRG_BITS     = 4,
  parameter int PRG_LSB      = 2,
  parameter int CHR_BITS     = 2,
  parameter int CHR_LSB      = 0,
  parameter int PRG_MODE     = 0,
  parameter int MIR_EN       = 0,
  parameter int MIR_POS      = 7,
  parameter int BUS_CONFLICT = 0,
  parameter int LOCK_EN      = 0
) (
  input  logic        i_m2,
  input  logic        i_map_rst_n,
  input  logic [14:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_dat,
  input  logic [7:0]  i_rom_dat,
  input  logic        i_cpu_rw,
  input  logic        i_cpu_ce,
  input  logic [13:0] i_ppu_addr,
  input  logic        i_cfg_mir_v,
  input  logic        i_ss_act,
  input  logic        i_ss_we,
  input  logic [7:0]  i_ss_addr,
  input  logic [7:0]  i_map_idx,
  output logic [21:0] o_prg_addr,
  output logic [19:0] o_chr_addr,
  output logic        o_ciram_a10,
  output logic [7:0]  o_ss_rdat,
  output logic        o_bank_locked
);

  localparam int CW      = (CHR_BITS > 0) ? CHR_BITS : 1;
  localparam int PRG_MSK = ((1 << PRG_BITS) - 1) << PRG_LSB;
  localparam int CHR_MSK = ((1 << CHR_BITS) - 1) << CHR_LSB;
  localparam int MIR_MSK = (MIR_EN != 0) ? (1 << MIR_POS) : 0;

  // Field layout must fit the written byte without overlap.
  if (PRG_BITS < 1 || PRG_BITS > 6 || PRG_LSB < 0 || PRG_LSB + PRG_BITS > 8) begin : g_bad_prg
    $error("latch_mapper_gen: PRG field outside bits 7..0 or PRG_BITS not in 1..6");
  end
  if (CHR_BITS < 0 || CHR_BITS > 4 || CHR_LSB < 0 || CHR_LSB + CHR_BITS > 8) begin : g_bad_chr
    $error("latch_mapper_gen: CHR field outside bits 7..0 or CHR_BITS not in 0..4");
  end
  if (MIR_EN != 0 && (MIR_POS < 0 || MIR_POS > 7)) begin : g_bad_mir
    $error("latch_mapper_gen: MIR_POS outside bits 7..0");
  end
  if (((PRG_MSK & CHR_MSK) | (PRG_MSK & MIR_MSK) | (CHR_MSK & MIR_MSK)) != 0) begin : g_bad_ovl
    $error("latch_mapper_gen: PRG, CHR and MIR fields overlap");
  end
  if (PRG_MODE < 0 || PRG_MODE > 2) begin : g_bad_mode
    $error("latch_mapper_gen: PRG_MODE must be 0, 1 or 2");
  end

  logic [PRG_BITS-1:0] r_prg;
  logic [CW-1:0]       r_chr;
  logic                r_mir;
  logic                r_lock;

  logic [7:0]          w_v;
  logic                w_wr;
  logic [CW-1:0]       w_wr_chr;
  logic [CW-1:0]       w_ss_chr;
  logic [PRG_BITS-1:0] w_bank;
  logic                w_unused;

  assign w_v  = (BUS_CONFLICT != 0) ? (i_cpu_dat & i_rom_dat) : i_cpu_dat;
  assign w_wr = !i_cpu_ce && !i_cpu_rw && ((LOCK_EN == 0) || !r_lock);
  assign w_unused = &{1'b0, i_ppu_addr[13], w_v};

  // A zero-width CHR field keeps a single register bit tied low.
  if (CHR_BITS > 0) begin : g_chr
    assign w_wr_chr = w_v[CHR_LSB +: CW];
    assign w_ss_chr = i_cpu_dat[CW-1:0];
  end else begin : g_no_chr
    assign w_wr_chr = 1'b0;
    assign w_ss_chr = 1'b0;
  end

  // Latch update on M2 fall: save-state load, then reset, then CPU write.
  always_ff @(negedge i_m2) begin
    if (i_ss_act) begin
      if (i_ss_we) begin
        case (i_ss_addr)
          8'd0: r_prg <= i_cpu_dat[PRG_BITS-1:0];
          8'd1: begin
            r_chr  <= w_ss_chr;
            r_mir  <= i_cpu_dat[6];
            r_lock <= (LOCK_EN != 0) ? i_cpu_dat[7] : 1'b0;
          end
          default: ;
        endcase
      end
    end else if (!i_map_rst_n) begin
      r_prg  <= '0;
      r_chr  <= '0;
      r_mir  <= 1'b0;
      r_lock <= 1'b0;
    end else if (w_wr) begin
      r_prg <= w_v[PRG_LSB +: PRG_BITS];
      r_chr <= w_wr_chr;
      if (MIR_EN != 0) begin
        r_mir <= w_v[MIR_POS];
      end
      if (LOCK_EN != 0) begin
        r_lock <= 1'b1;
      end
    end
  end

  // PRG/CHR address translation and nametable select.
  always_comb begin
    w_bank = r_prg;
    if (PRG_MODE == 1 && i_cpu_addr[14]) begin
      w_bank = '1;
    end else begin
      w_bank = r_prg;
    end
    if (PRG_MODE == 2) begin
      o_prg_addr = (22'(r_prg) << 5'd15) | 22'(i_cpu_addr);
    end else begin
      o_prg_addr = (22'(w_bank) << 5'd14) | 22'(i_cpu_addr[13:0]);
    end
    o_chr_addr = (20'(r_chr) << 5'd13) | 20'(i_ppu_addr[12:0]);
    if (MIR_EN != 0) begin
      o_ciram_a10 = r_mir ? i_ppu_addr[11] : i_ppu_addr[10];
    end else begin
      o_ciram_a10 = i_cfg_mir_v ? i_ppu_addr[10] : i_ppu_addr[11];
    end
  end

  // Save-state readback.
  always_comb begin
    o_ss_rdat = 8'hFF;
    case (i_ss_addr)
      8'd0:    o_ss_rdat = 8'(r_prg);
      8'd1:    o_ss_rdat = {r_lock, r_mir, 6'(r_chr)};
      8'd127:  o_ss_rdat = i_map_idx;
      default: o_ss_rdat = 8'hFF;
    endcase
  end

  assign o_bank_locked = r_lock;

endmodule
